// File: rtl/ld_alloc_pkg.sv
// Shared types for the linked-data slot allocator.
//   alloc_state_e : offer FSM state (no offer pending / offer pending)
package ld_alloc_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StOffer = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/ld_first_free.sv
// Combinational find-first-set with a rotating start position.
//   vec_i    : candidate vector, bit i set = slot i selectable
//   offset_i : first index examined; the search wraps past Width-1 to 0
//   idx_o    : first set index at or after offset_i (0 when none)
//   found_o  : at least one bit of vec_i is set
module ld_first_free #(
  parameter int unsigned Width = 16,
  localparam int unsigned IdxW = $clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  input  logic [IdxW-1:0]  offset_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  always_comb begin : p_find
    int unsigned pos;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned k = 0; k < Width; k++) begin
      // offset_i is always below Width, so one subtraction is enough to wrap
      pos = 32'(offset_i) + k;
      if (pos >= Width) begin
        pos = pos - Width;
      end
      if (!found_o && vec_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/ld_alloc.sv
// Free-slot allocator for the linked-data table. One free index is reserved
// and offered at a time on a valid/ready port; slots come back through a
// single release port.
//   alloc_valid_o/alloc_ready_i/alloc_idx_o : registered offer of a reserved slot
//   rel_valid_i/rel_idx_i                   : release of a busy slot
//   rel_err_o                               : one-cycle pulse after an illegal release
//   free_o                                  : slot neither busy nor offered
//   num_busy_o, full_o, empty_o             : occupancy of handshaked slots
module ld_alloc
  import ld_alloc_pkg::*;
#(
  parameter int unsigned MaxTxns    = 16,
  parameter bit          RoundRobin = 1'b0,
  localparam int unsigned IdxW      = $clog2(MaxTxns),
  localparam int unsigned CntW      = $clog2(MaxTxns + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               alloc_valid_o,
  input  logic               alloc_ready_i,
  output logic [IdxW-1:0]    alloc_idx_o,
  input  logic               rel_valid_i,
  input  logic [IdxW-1:0]    rel_idx_i,
  output logic               rel_err_o,
  output logic [MaxTxns-1:0] free_o,
  output logic [CntW-1:0]    num_busy_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned PadW = 2 ** IdxW;

  alloc_state_e     state_q, state_d;
  logic [MaxTxns-1:0] free_q, free_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [CntW-1:0]  num_busy_q, num_busy_d;
  logic             rel_err_q, rel_err_d;

  logic             hs;
  logic             load;
  logic             rel_ok;
  logic [PadW-1:0]  free_pad;
  logic [IdxW-1:0]  idx_inc;
  logic [IdxW-1:0]  search_off;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_found;

  assign hs = (state_q == StOffer) && alloc_ready_i;

  // Padded copy so out-of-range release indices read a harmless zero.
  assign free_pad = PadW'(free_q);

  // Legal only for a busy slot: in range, not free, and not the pending offer.
  assign rel_ok = rel_valid_i && (32'(rel_idx_i) < MaxTxns) && !free_pad[rel_idx_i] &&
                  !((state_q == StOffer) && (rel_idx_i == idx_q));

  assign idx_inc = (idx_q == IdxW'(MaxTxns - 1)) ? '0 : idx_q + IdxW'(1);

  // On a handshake the pointer moves in the same cycle, so search from the
  // updated position to keep back-to-back allocation in round-robin order.
  assign search_off = RoundRobin ? (hs ? idx_inc : rr_q) : '0;

  // Searching the registered vector means a slot released this cycle is
  // not selectable until the next one.
  ld_first_free #(
    .Width (MaxTxns)
  ) u_first_free (
    .vec_i    (free_q),
    .offset_i (search_off),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign load = pick_found && ((state_q == StIdle) || hs);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_found) state_d = StOffer;
      StOffer: if (hs && !pick_found) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    alloc_valid_o = (state_q == StOffer);
  end

  // Datapath next state
  always_comb begin
    free_d = free_q;
    if (rel_ok) begin
      free_d[rel_idx_i] = 1'b1;
    end
    // The picked slot is free in free_q, so it never collides with the release.
    if (load) begin
      free_d[pick_idx] = 1'b0;
    end
    idx_d      = load ? pick_idx : idx_q;
    rr_d       = (RoundRobin && hs) ? idx_inc : rr_q;
    num_busy_d = num_busy_q + CntW'(hs) - CntW'(rel_ok);
    rel_err_d  = rel_valid_i && !rel_ok;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q     <= '1;
      idx_q      <= '0;
      rr_q       <= '0;
      num_busy_q <= '0;
      rel_err_q  <= 1'b0;
    end else begin
      free_q     <= free_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      num_busy_q <= num_busy_d;
      rel_err_q  <= rel_err_d;
    end
  end

  assign alloc_idx_o = idx_q;
  assign rel_err_o   = rel_err_q;
  assign free_o      = free_q;
  assign num_busy_o  = num_busy_q;
  assign full_o      = (num_busy_q == CntW'(MaxTxns));
  assign empty_o     = (num_busy_q == '0);

endmodule

// File: tb/tb_ld_alloc.sv
// Scoreboard bench for ld_alloc: two instances (4 slots lowest-index, 5 slots
// round-robin) share stimulus; a slot-state reference model predicts each
// cycle's outputs into per-instance queues that a negedge monitor drains.
module tb_ld_alloc;

  typedef struct {
    int valid;
    int idx;
    int free_v;
    int nb;
    int full;
    int empty;
    int err;
  } snap_t;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic       rv;
  logic [2:0] ridx;

  logic       lo_valid, lo_err, lo_full, lo_empty;
  logic [1:0] lo_idx;
  logic [3:0] lo_free;
  logic [2:0] lo_nb;

  logic       rr_valid, rr_err, rr_full, rr_empty;
  logic [2:0] rr_idx;
  logic [4:0] rr_free;
  logic [2:0] rr_nb;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  snap_t q0[$];
  snap_t q1[$];

  // Reference model: per slot 0=free 1=offered 2=busy
  int st[2][8];
  bit ov[2];
  int oi[2];
  int rrp[2];
  bit er[2];

  ld_alloc #(
    .MaxTxns    (4),
    .RoundRobin (1'b0)
  ) u_lo (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alloc_valid_o (lo_valid),
    .alloc_ready_i (rdy),
    .alloc_idx_o   (lo_idx),
    .rel_valid_i   (rv),
    .rel_idx_i     (ridx[1:0]),
    .rel_err_o     (lo_err),
    .free_o        (lo_free),
    .num_busy_o    (lo_nb),
    .full_o        (lo_full),
    .empty_o       (lo_empty)
  );

  ld_alloc #(
    .MaxTxns    (5),
    .RoundRobin (1'b1)
  ) u_rr (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alloc_valid_o (rr_valid),
    .alloc_ready_i (rdy),
    .alloc_idx_o   (rr_idx),
    .rel_valid_i   (rv),
    .rel_idx_i     (ridx),
    .rel_err_o     (rr_err),
    .free_o        (rr_free),
    .num_busy_o    (rr_nb),
    .full_o        (rr_full),
    .empty_o       (rr_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nslots(input int u);
    return (u == 0) ? 4 : 5;
  endfunction

  task automatic model_step(input int u, input bit rst, input bit rdy_b, input bit rv_b,
                            input int ridx_v);
    int  n;
    bit  hs;
    bit  legal;
    bit  need;
    int  start;
    int  j;
    bit  was_free[8];
    n = nslots(u);
    if (!rst) begin
      for (int i = 0; i < 8; i++) st[u][i] = 0;
      ov[u]  = 1'b0;
      oi[u]  = 0;
      rrp[u] = 0;
      er[u]  = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) was_free[i] = (i < n) && (st[u][i] == 0);
      hs    = ov[u] && rdy_b;
      legal = rv_b && (ridx_v < n) && (st[u][ridx_v] == 2);
      er[u] = rv_b && !legal;
      need  = !ov[u] || hs;
      if (u == 1) start = hs ? (oi[u] + 1) % n : rrp[u];
      else        start = 0;
      if (hs) begin
        st[u][oi[u]] = 2;
        if (u == 1) rrp[u] = (oi[u] + 1) % n;
      end
      if (need) begin
        ov[u] = 1'b0;
        for (int k = 0; k < n; k++) begin
          j = (start + k) % n;
          if (!ov[u] && was_free[j]) begin
            ov[u]    = 1'b1;
            oi[u]    = j;
            st[u][j] = 1;
          end
        end
      end
      if (legal) st[u][ridx_v] = 0;
    end
  endtask

  function automatic snap_t snap(input int u);
    snap_t s;
    int    n;
    n        = nslots(u);
    s.valid  = int'(ov[u]);
    s.idx    = oi[u];
    s.free_v = 0;
    s.nb     = 0;
    for (int i = 0; i < n; i++) begin
      if (st[u][i] == 0) s.free_v = s.free_v | (1 << i);
      if (st[u][i] == 2) s.nb = s.nb + 1;
    end
    s.full  = (s.nb == n) ? 1 : 0;
    s.empty = (s.nb == 0) ? 1 : 0;
    s.err   = int'(er[u]);
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks = checks + 1;
    if (act != exp_v) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : p_mon
    snap_t e;
    if (mon_en) begin
      if (q0.size() == 0) begin
        chk("lo.queue_underflow", 0, 1);
      end else begin
        e = q0.pop_front();
        chk("lo.alloc_valid", int'(lo_valid), e.valid);
        if (e.valid != 0) chk("lo.alloc_idx", int'(lo_idx), e.idx);
        chk("lo.free", int'(lo_free), e.free_v);
        chk("lo.num_busy", int'(lo_nb), e.nb);
        chk("lo.full", int'(lo_full), e.full);
        chk("lo.empty", int'(lo_empty), e.empty);
        chk("lo.rel_err", int'(lo_err), e.err);
      end
      if (q1.size() == 0) begin
        chk("rr.queue_underflow", 0, 1);
      end else begin
        e = q1.pop_front();
        chk("rr.alloc_valid", int'(rr_valid), e.valid);
        if (e.valid != 0) chk("rr.alloc_idx", int'(rr_idx), e.idx);
        chk("rr.free", int'(rr_free), e.free_v);
        chk("rr.num_busy", int'(rr_nb), e.nb);
        chk("rr.full", int'(rr_full), e.full);
        chk("rr.empty", int'(rr_empty), e.empty);
        chk("rr.rel_err", int'(rr_err), e.err);
      end
    end
  end

  // Inputs change 1 time unit after the falling edge; the model predicts
  // what the monitor should see at the following falling edge.
  task automatic cyc(input bit r, input bit a, input bit v, input int i);
    @(negedge clk);
    #1;
    rst_n = r;
    rdy   = a;
    rv    = v;
    ridx  = 3'(i);
    model_step(0, r, a, v, i & 3);
    model_step(1, r, a, v, i & 7);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    mon_en = 1'b1;
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : p_stim
    rst_n = 1'b0;
    rdy   = 1'b0;
    rv    = 1'b0;
    ridx  = '0;
    for (int c = 0; c < 3; c++) cyc(0, 0, 0, 0);
    // Drain: ready held high straight out of reset
    for (int c = 0; c < 6; c++) cyc(1, 1, 0, 0);
    // Release while full, then take the re-offered slot
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    // Backpressure with a release of a busy slot mid-wait
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 2);
    for (int c = 0; c < 3; c++) cyc(1, 0, 0, 0);
    // Illegal releases: offered slot, free slot, out of range
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 2);
    cyc(1, 0, 1, 4);
    cyc(1, 0, 1, 7);
    // Handshakes, including one coinciding with a release
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    cyc(1, 0, 1, 3);
    cyc(1, 1, 1, 0);
    // Reset with an offer pending
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom % 80) != 0, ($urandom % 3) != 0, ($urandom % 5) < 2, int'($urandom % 8));
    end
    cyc(1, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drain", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
